// File: rtl/run_sequencer_pkg.sv
// Shared types for the run sequencer: FSM states, completion status codes and sizing helpers.
package run_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } run_state_t;

  typedef enum logic [1:0] {
    ST_OK,
    ST_TIMEOUT,
    ST_BAD_PROG,
    ST_ABORTED
  } run_status_t;

  localparam int unsigned STATUS_BITS = 2;

  // Width of a program index; a single-program build still needs one select bit.
  function automatic int unsigned sel_width(input int unsigned num_progs);
    return (num_progs > 1) ? $clog2(num_progs) : 1;
  endfunction

endpackage

// File: rtl/run_sequencer_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/run_sequencer.sv
// Host req/ack front end for the core: picks a program, pulses the core start,
// watches the PC for that program's done address and reports status with a cycle count.
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int unsigned PC_BITS      = 10,
  parameter int unsigned NUM_PROGS    = 3,
  parameter int unsigned SEL_BITS     = sel_width(NUM_PROGS),
  parameter int unsigned CYC_BITS     = 16,
  parameter int unsigned MAX_CYCLES   = 50000,
  parameter int unsigned START_CYCLES = 2
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           req,
  input  logic [SEL_BITS-1:0]            prog_sel,
  input  logic [NUM_PROGS*PC_BITS-1:0]   start_addr_tbl,
  input  logic [NUM_PROGS*PC_BITS-1:0]   done_addr_tbl,
  input  logic [PC_BITS-1:0]             pc,
  output logic                           core_start,
  output logic [PC_BITS-1:0]             core_start_addr,
  output logic                           ack,
  output logic                           busy,
  output logic [STATUS_BITS-1:0]         status,
  output logic [CYC_BITS-1:0]            cycle_count
);

  localparam int unsigned LOAD_BITS = $clog2(START_CYCLES + 1);
  localparam int unsigned SEL_W1    = SEL_BITS + 1;
  localparam logic [SEL_W1-1:0]    PROG_LIMIT = SEL_W1'(NUM_PROGS);
  localparam logic [CYC_BITS-1:0]  CYC_LIMIT  = CYC_BITS'(MAX_CYCLES);
  localparam logic [LOAD_BITS-1:0] LOAD_LAST  = LOAD_BITS'(START_CYCLES - 1);

  run_state_t          state_q, state_d;
  run_status_t         status_q, status_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                core_start_q, core_start_d;
  logic [PC_BITS-1:0]  addr_q, addr_d;
  logic [SEL_BITS-1:0] prog_q, prog_d;

  logic                 cyc_clr, cyc_en;
  logic                 ld_clr, ld_en;
  logic [CYC_BITS-1:0]  cyc_cnt;
  logic [CYC_BITS-1:0]  cyc_next;
  logic [LOAD_BITS-1:0] ld_cnt;
  logic                 sel_valid;
  logic                 pc_match;
  logic                 timeout_hit;

  logic [PC_BITS-1:0] start_tbl [NUM_PROGS];
  logic [PC_BITS-1:0] done_tbl  [NUM_PROGS];

  for (genvar i = 0; i < NUM_PROGS; i++) begin : g_tbl
    assign start_tbl[i] = start_addr_tbl[i*PC_BITS +: PC_BITS];
    assign done_tbl[i]  = done_addr_tbl[i*PC_BITS +: PC_BITS];
  end

  sat_counter #(.WIDTH(CYC_BITS)) u_cyc_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (cyc_clr),
    .enable  (cyc_en),
    .count   (cyc_cnt)
  );

  sat_counter #(.WIDTH(LOAD_BITS)) u_load_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (ld_clr),
    .enable  (ld_en),
    .count   (ld_cnt)
  );

  // Timeout is judged on the post-increment count so the budget covers exactly MAX_CYCLES RUN cycles.
  assign cyc_next    = (&cyc_cnt) ? cyc_cnt : cyc_cnt + CYC_BITS'(1);
  assign timeout_hit = (cyc_next == CYC_LIMIT);
  assign pc_match    = (pc == done_tbl[prog_q]);
  assign sel_valid   = ({1'b0, prog_sel} < PROG_LIMIT);

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    addr_d   = addr_q;
    prog_d   = prog_q;
    cyc_clr  = 1'b0;
    cyc_en   = 1'b0;
    ld_clr   = 1'b0;
    ld_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req && !ack_q) begin
          cyc_clr = 1'b1;
          if (sel_valid) begin
            prog_d   = prog_sel;
            addr_d   = start_tbl[prog_sel];
            status_d = ST_OK;
            ld_clr   = 1'b1;
            state_d  = LOAD;
          end else begin
            status_d = ST_BAD_PROG;
            state_d  = DONE;
          end
        end
      end
      LOAD: begin
        if (!req) begin
          status_d = ST_ABORTED;
          state_d  = IDLE;
        end else if (ld_cnt == LOAD_LAST) begin
          state_d = RUN;
        end else begin
          ld_en = 1'b1;
        end
      end
      RUN: begin
        // Abort beats match beats timeout; an aborting cycle is not counted.
        if (!req) begin
          status_d = ST_ABORTED;
          state_d  = IDLE;
        end else begin
          cyc_en = 1'b1;
          if (pc_match) begin
            status_d = ST_OK;
            state_d  = DONE;
          end else if (timeout_hit) begin
            status_d = ST_TIMEOUT;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (!req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    core_start_d = (state_d == LOAD);
    busy_d       = (state_d == LOAD) || (state_d == RUN);
    ack_d        = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      status_q     <= ST_OK;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      core_start_q <= 1'b0;
      addr_q       <= '0;
      prog_q       <= '0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      core_start_q <= core_start_d;
      addr_q       <= addr_d;
      prog_q       <= prog_d;
    end
  end

  assign core_start      = core_start_q;
  assign core_start_addr = addr_q;
  assign ack             = ack_q;
  assign busy            = busy_q;
  assign status          = status_q;
  assign cycle_count     = cyc_cnt;

endmodule
